sram_controller: RTL and testbench

Synchronous sequencer and two-port arbiter for the asynchronous single-port `sram` macro (active-low `chip_enable`, `write_enable` and `output_enable`, bidirectional `data`). It accepts read and write requests from two on-chip requesters, serialises them onto the SRAM pins with guaranteed setup, strobe and hold cycles, and returns read data on a registered output. The block sits between the core/loader logic and the `sram` instance. It is the only driver of the SRAM control pins.

---
 rtl/sram_controller.sv | 152 +++++++++++++++
 tb/tb_sram_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// Sequencer and two-port arbiter for an asynchronous single-port SRAM with active-low strobes.
// Define SRAM_CONTROLLER_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (port 0) otherwise.
module sram_controller #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_CYCLES = 2   // legal range 1..15
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              request,
  input  logic [1:0]              write,
  input  logic [2*ADDR_WIDTH-1:0] address,
  input  logic [2*DATA_WIDTH-1:0] write_data,
  output logic [1:0]              done,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   sram_address,
  inout  wire  [DATA_WIDTH-1:0]   sram_data,
  output logic                    sram_chip_enable,
  output logic                    sram_write_enable,
  output logic                    sram_output_enable
);

  typedef enum logic [1:0] {StIdle, StSetup, StActive, StRecover} state_e;

  localparam logic [3:0] LastCount = 4'(WAIT_CYCLES - 1);

  state_e                  state_q;
  logic                    port_q;
  logic                    write_q;
  logic                    drive_q;
  logic [3:0]              count_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              done_q;
  logic                    busy_q;
  logic                    ce_n_q;
  logic                    we_n_q;
  logic                    oe_n_q;

  logic                    grant;
  logic                    sel_write;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

`ifdef SRAM_CONTROLLER_ROUND_ROBIN_EN
  // Port that wins the next tie; flips to the other port on every grant.
  logic prio_q;

  always_comb begin
    grant = 1'b0;
    if (request == 2'b11) begin
      grant = prio_q;
    end else begin
      grant = ~request[0];
    end
  end
`else
  always_comb begin
    grant = ~request[0];
  end
`endif

  always_comb begin
    sel_write = grant ? write[1] : write[0];
    sel_addr  = grant ? address[2*ADDR_WIDTH-1:ADDR_WIDTH] : address[ADDR_WIDTH-1:0];
    sel_wdata = grant ? write_data[2*DATA_WIDTH-1:DATA_WIDTH] : write_data[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      port_q  <= 1'b0;
      write_q <= 1'b0;
      drive_q <= 1'b0;
      count_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      ce_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
`ifdef SRAM_CONTROLLER_ROUND_ROBIN_EN
      prio_q  <= 1'b0;
`endif
    end else begin
      done_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (|request) begin
            port_q  <= grant;
            write_q <= sel_write;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            drive_q <= sel_write;
            ce_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StSetup;
`ifdef SRAM_CONTROLLER_ROUND_ROBIN_EN
            prio_q  <= ~grant;
`endif
          end
        end
        StSetup: begin
          count_q <= LastCount;
          if (write_q) begin
            we_n_q <= 1'b0;
          end else begin
            oe_n_q <= 1'b0;
          end
          state_q <= StActive;
        end
        StActive: begin
          if (count_q == '0) begin
            // Read data is sampled while output_enable is still low.
            if (!write_q) begin
              rdata_q <= sram_data;
            end
            we_n_q         <= 1'b1;
            oe_n_q         <= 1'b1;
            done_q[port_q] <= 1'b1;
            state_q        <= StRecover;
          end else begin
            count_q <= count_q - 4'd1;
          end
        end
        StRecover: begin
          ce_n_q  <= 1'b1;
          drive_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign sram_data          = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};
  assign sram_address       = addr_q;
  assign sram_chip_enable   = ce_n_q;
  assign sram_write_enable  = we_n_q;
  assign sram_output_enable = oe_n_q;
  assign read_data          = rdata_q;
  assign done               = done_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: three instances (WAIT_CYCLES 2, 1, 4) each on an async SRAM model.
module tb_sram_controller;

  localparam int NI = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [1:0]  req   [NI];
  logic [1:0]  wr    [NI];
  logic [15:0] addr  [NI];
  logic [31:0] wdat  [NI];
  logic [1:0]  done  [NI];
  logic [15:0] rdata [NI];
  logic        busy  [NI];
  logic [7:0]  sa    [NI];
  logic        ce    [NI];
  logic        we    [NI];
  logic        oe    [NI];
  logic [15:0] bus   [NI];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int mon_bad = 0;
  bit mon_en  = 1'b0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    wire  [15:0] sd;
    logic [15:0] mem [256];

    // Undriven bus reads as all ones, so any stray controller drive is visible.
    pullup (sd);
    assign sd     = (!ce[g] && !oe[g]) ? mem[sa[g]] : 16'bz;
    assign bus[g] = sd;

    initial begin
      for (int i = 0; i < 256; i++) mem[i] = {~i[7:0], i[7:0]};
      mem[8'h7C] = 16'hB7F8;
      forever begin
        @(posedge we[g]);
        if (!ce[g]) mem[sa[g]] = sd;
      end
    end

    sram_controller #(
      .DATA_WIDTH (16),
      .ADDR_WIDTH (8),
      .WAIT_CYCLES((g == 0) ? 2 : (g == 1) ? 1 : 4)
    ) u_dut (
      .clock             (clock),
      .reset             (reset),
      .request           (req[g]),
      .write             (wr[g]),
      .address           (addr[g]),
      .write_data        (wdat[g]),
      .done              (done[g]),
      .read_data         (rdata[g]),
      .busy              (busy[g]),
      .sram_address      (sa[g]),
      .sram_data         (sd),
      .sram_chip_enable  (ce[g]),
      .sram_write_enable (we[g]),
      .sram_output_enable(oe[g])
    );
  end

  always @(negedge clock) begin
    if (mon_en) begin
      for (int k = 0; k < NI; k++) begin
        assert (oe[k] || (we[k] && !ce[k])) else begin
          mon_bad++;
          $error("FAIL strobe_k%0d: observed ce=%b we=%b oe=%b, required ce=0 we=1 while oe=0",
                 k, ce[k], we[k], oe[k]);
        end
        assert (!ce[k] || bus[k] === 16'hFFFF) else begin
          mon_bad++;
          $error("FAIL idle_bus_k%0d: observed %h required ffff (undriven)", k, bus[k]);
        end
      end
    end
  end

  function automatic int wait_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 4;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance k, port p; d is the write word or the expected read word.
  task automatic txn(input int k, input int p, input bit w, input logic [7:0] a,
                     input logic [15:0] d);
    int          wc      = wait_of(k);
    int          lat     = 0;
    int          we_low  = 0;
    int          oe_low  = 0;
    bit          seen    = 1'b0;
    logic [15:0] b_setup = '0;
    logic [15:0] b_rec   = '0;
    string       t       = $sformatf("k%0d_p%0d_%s_%02h", k, p, w ? "wr" : "rd", a);
    addr[k][p*8 +: 8]  = a;
    wdat[k][p*16 +: 16] = w ? d : 16'h0;
    wr[k][p]  = w;
    req[k][p] = 1'b1;
    while (!seen && lat < 30) begin
      tick();
      lat++;
      if (!we[k]) we_low++;
      if (!oe[k]) oe_low++;
      if (lat == 1) b_setup = bus[k];
      if (done[k][p]) begin
        seen      = 1'b1;
        b_rec     = bus[k];
        req[k][p] = 1'b0;
      end
    end
    chk({t, "_done_seen"}, 32'(seen), 32'd1);
    chk({t, "_latency"}, lat, wc + 2);
    chk({t, "_we_low_cycles"}, we_low, w ? wc : 0);
    chk({t, "_oe_low_cycles"}, oe_low, w ? 0 : wc);
    chk({t, "_bus_setup"}, b_setup, w ? d : 16'hFFFF);
    chk({t, "_bus_recover"}, b_rec, w ? d : 16'hFFFF);
    chk({t, "_sram_address"}, sa[k], a);
    if (!w) chk({t, "_read_data"}, rdata[k], d);
    tick();
    chk({t, "_idle_busy"}, busy[k], 0);
    chk({t, "_idle_done"}, done[k], 0);
  endtask

  initial begin
    logic [1:0] got [4];
    int         cyc [4];
    int         n;
    int         c;
    logic [1:0] done_or;

    for (int k = 0; k < NI; k++) begin
      req[k] = '0; wr[k] = '0; addr[k] = '0; wdat[k] = '0;
    end
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_k%0d_done", k), done[k], 0);
      chk($sformatf("rst_k%0d_busy", k), busy[k], 0);
      chk($sformatf("rst_k%0d_addr", k), sa[k], 0);
      chk($sformatf("rst_k%0d_rdata", k), rdata[k], 0);
      chk($sformatf("rst_k%0d_strobes", k), {ce[k], we[k], oe[k]}, 3'b111);
      chk($sformatf("rst_k%0d_bus", k), bus[k], 16'hFFFF);
    end
    mon_en = 1'b1;

    // Basic write/read and port 1 read of preloaded word.
    txn(0, 0, 1'b1, 8'h05, 16'h1234);
    txn(0, 0, 1'b0, 8'h05, 16'h1234);
    txn(0, 1, 1'b0, 8'h7C, 16'hB7F8);

    // Both ports request continuously.
    addr[0] = {8'h20, 8'h10};
    wdat[0] = {16'hB020, 16'hA010};
    wr[0]   = 2'b11;
    req[0]  = 2'b11;
    n = 0;
    c = 0;
    for (int i = 0; i < 4; i++) begin
      got[i] = '0;
      cyc[i] = 0;
    end
    while (n < 4 && c < 60) begin
      tick();
      c++;
      if (done[0] != 2'b00) begin
        got[n] = done[0];
        cyc[n] = c;
        n++;
      end
    end
    req[0] = 2'b00;
    chk("arb_grant_count", n, 4);
`ifdef SRAM_CONTROLLER_ROUND_ROBIN_EN
    chk("arb_grant0", got[0], 2'b01);
    chk("arb_grant1", got[1], 2'b10);
    chk("arb_grant2", got[2], 2'b01);
    chk("arb_grant3", got[3], 2'b10);
`else
    chk("arb_grant0", got[0], 2'b01);
    chk("arb_grant1", got[1], 2'b01);
    chk("arb_grant2", got[2], 2'b01);
    chk("arb_grant3", got[3], 2'b01);
`endif
    for (int i = 0; i < 4; i++) chk($sformatf("arb_done_cycle%0d", i), cyc[i], 4 + 5 * i);
    tick();
    chk("arb_idle_busy", busy[0], 0);
    txn(0, 1, 1'b0, 8'h10, 16'hA010);
`ifdef SRAM_CONTROLLER_ROUND_ROBIN_EN
    txn(0, 0, 1'b0, 8'h20, 16'hB020);
`else
    txn(0, 0, 1'b0, 8'h20, 16'hDF20);
`endif

    // Reset during ACTIVE of a write.
    addr[0][7:0]  = 8'h30;
    wdat[0][15:0] = 16'h5555;
    wr[0][0]      = 1'b1;
    req[0][0]     = 1'b1;
    tick();
    tick();
    chk("rstmid_active_we", we[0], 0);
    chk("rstmid_active_busy", busy[0], 1);
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    req[0] = 2'b00;
    chk("rstmid_strobes", {ce[0], we[0], oe[0]}, 3'b111);
    chk("rstmid_bus", bus[0], 16'hFFFF);
    chk("rstmid_busy", busy[0], 0);
    chk("rstmid_rdata", rdata[0], 0);
    chk("rstmid_addr", sa[0], 0);
    done_or = done[0];
    for (int i = 0; i < 6; i++) begin
      tick();
      done_or = done_or | done[0];
    end
    chk("rstmid_no_done", done_or, 0);
    txn(0, 0, 1'b0, 8'h05, 16'h1234);

    // Short and long strobe variants.
    for (int k = 1; k < NI; k++) begin
      txn(k, 0, 1'b1, 8'h40, 16'h1357);
      txn(k, 1, 1'b0, 8'h40, 16'h1357);
      txn(k, 1, 1'b1, 8'h41, 16'h2468);
      txn(k, 0, 1'b0, 8'h41, 16'h2468);
      txn(k, 0, 1'b0, 8'h7C, 16'hB7F8);
    end

    chk("bus_monitor_violations", mon_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
